output_mems: RTL and testbench

- Result-side counterpart to the input memory loader: holds the M x N result matrix C written by the MAC array.
- Once the compute engine signals completion, streams C out as an AXI-Stream master, row-major, one element per beat, with TLAST on the final element.
- Sits between the compute datapath and the top-level output AXIS port.
- Back-pressures the compute engine through output_ready while a stream is in progress.

---
 rtl/output_mems_pkg.sv | 20 ++
 rtl/output_mems_memory.sv | 28 ++
 rtl/output_mems.sv | 97 +++++++++
 tb/tb_output_mems.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/output_mems_pkg.sv
// Shared types and defaults for the result-matrix output stage.
// Holds the default matrix geometry and the streaming FSM state type.
package output_mems_pkg;

  localparam int DEFAULT_M    = 7;
  localparam int DEFAULT_N    = 9;
  localparam int DEFAULT_OUTW = 28;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM
  } stream_state_e;

  // Number of result elements in an M x N matrix.
  function automatic int elemCount(input int rows, input int cols);
    return rows * cols;
  endfunction

endpackage

// File: rtl/output_mems_memory.sv
// Generic single-write-port memory with a registered (1-cycle latency) read port.
// Writes to addresses at or beyond SIZE are dropped; contents are never cleared.
module memory #(
  parameter int WIDTH     = 28,
  parameter int SIZE      = 63,
  parameter int ADDR_BITS = $clog2(SIZE)
) (
  input  logic                 clk,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [WIDTH-1:0]     rd_data_o
);

  logic [WIDTH-1:0] mem_q [SIZE];

  always_ff @(posedge clk) begin
    if (wr_en_i && (32'(wr_addr_i) < SIZE)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/output_mems.sv
// Result matrix buffer: captures C from the MAC array while idle, then streams it
// row-major as an AXI-Stream master with TLAST on the final element.
module output_mems
  import output_mems_pkg::*;
#(
  parameter int OUTW = DEFAULT_OUTW,
  parameter int M    = DEFAULT_M,
  parameter int N    = DEFAULT_N,
  localparam int C_ADDR_BITS = $clog2(elemCount(M, N))
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   C_wr_en,
  input  logic [C_ADDR_BITS-1:0] C_wr_addr,
  input  logic [OUTW-1:0]        C_wr_data,
  input  logic                   compute_finished,
  output logic                   output_ready,
  output logic [OUTW-1:0]        AXIS_TDATA,
  output logic                   AXIS_TVALID,
  output logic                   AXIS_TLAST,
  input  logic                   AXIS_TREADY
);

  localparam int ELEMS = elemCount(M, N);
  localparam logic [C_ADDR_BITS-1:0] LAST_IDX = C_ADDR_BITS'(ELEMS - 1);

  stream_state_e          state_q, state_d;
  logic [C_ADDR_BITS-1:0] index_q, index_d;
  logic                   handshake;
  logic                   memWrEn;
  logic [OUTW-1:0]        rdData;

  assign handshake = (state_q == STREAM) && AXIS_TREADY;
  assign memWrEn   = C_wr_en && (state_q == IDLE) && (C_wr_addr <= LAST_IDX);

  // The read port follows index_d, so a stalled beat keeps re-reading the same
  // address and TDATA stays put; PRIME re-reads address 0 so a same-cycle write lands.
  memory #(
    .WIDTH     (OUTW),
    .SIZE      (ELEMS),
    .ADDR_BITS (C_ADDR_BITS)
  ) u_cmem (
    .clk       (clk),
    .wr_en_i   (memWrEn),
    .wr_addr_i (C_wr_addr),
    .wr_data_i (C_wr_data),
    .rd_addr_i (index_d),
    .rd_data_o (rdData)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    unique case (state_q)
      IDLE: begin
        if (compute_finished) begin
          state_d = PRIME;
          index_d = '0;
        end
      end
      PRIME: begin
        state_d = STREAM;
      end
      STREAM: begin
        if (handshake) begin
          // Wrapping to 0 keeps the read address inside the valid range.
          if (index_q == LAST_IDX) begin
            state_d = IDLE;
            index_d = '0;
          end else begin
            index_d = index_q + C_ADDR_BITS'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        index_d = '0;
      end
    endcase
  end

  assign output_ready = (state_q == IDLE);
  assign AXIS_TVALID  = (state_q == STREAM);
  assign AXIS_TLAST   = (state_q == STREAM) && (index_q == LAST_IDX);
  assign AXIS_TDATA   = rdData;

endmodule

// File: tb/tb_output_mems.sv
// Randomized self-checking bench for output_mems (M=2, N=3) against a simple
// array model of the result memory and the expected row-major stream.
module tb_output_mems;

  localparam int M     = 2;
  localparam int N     = 3;
  localparam int OUTW  = 28;
  localparam int ELEMS = M * N;
  localparam int AB    = $clog2(ELEMS);

  logic            clk = 1'b0;
  logic            reset;
  logic            C_wr_en;
  logic [AB-1:0]   C_wr_addr;
  logic [OUTW-1:0] C_wr_data;
  logic            compute_finished;
  logic            output_ready;
  logic [OUTW-1:0] AXIS_TDATA;
  logic            AXIS_TVALID;
  logic            AXIS_TLAST;
  logic            AXIS_TREADY;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [OUTW-1:0] refMem [ELEMS];
  logic            readyPattern [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  output_mems #(.OUTW(OUTW), .M(M), .N(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .C_wr_en          (C_wr_en),
    .C_wr_addr        (C_wr_addr),
    .C_wr_data        (C_wr_data),
    .compute_finished (compute_finished),
    .output_ready     (output_ready),
    .AXIS_TDATA       (AXIS_TDATA),
    .AXIS_TVALID      (AXIS_TVALID),
    .AXIS_TLAST       (AXIS_TLAST),
    .AXIS_TREADY      (AXIS_TREADY)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, where outputs are also settled.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // The model only records writes that land in the result range while idle.
  task automatic writeElem(input int addr, input logic [OUTW-1:0] data);
    C_wr_en   = 1'b1;
    C_wr_addr = AB'(addr);
    C_wr_data = data;
    tick();
    C_wr_en   = 1'b0;
    if (addr < ELEMS) refMem[addr] = data;
  endtask

  // readyMode: 0 always ready, 1 fixed pattern, 2 random. Other arguments name the
  // beat count at which to inject a stray write, a stray compute_finished, or reset.
  task automatic applyStimulus(input int readyMode, input int wrAtBeat, input int cfAtBeat, input int rstAtBeat);
    int   beats;
    int   cycles;
    logic ready;
    compute_finished = 1'b1;
    tick();
    compute_finished = 1'b0;
    C_wr_en          = 1'b0;
    checkOutput("primeValid", 64'(AXIS_TVALID), 64'd0);
    checkOutput("primeReady", 64'(output_ready), 64'd0);
    tick();
    checkOutput("firstValid", 64'(AXIS_TVALID), 64'd1);
    beats  = 0;
    cycles = 0;
    while (beats < ELEMS && cycles < 200) begin
      if (AXIS_TVALID !== 1'b1) begin
        checkOutput("validDrop", 64'(AXIS_TVALID), 64'd1);
        break;
      end
      checkOutput("tdata", 64'(AXIS_TDATA), 64'(refMem[beats]));
      checkOutput("tlast", 64'(AXIS_TLAST), 64'(beats == ELEMS - 1));
      checkOutput("busyReady", 64'(output_ready), 64'd0);
      case (readyMode)
        0:       ready = 1'b1;
        1:       ready = readyPattern[cycles % 8];
        default: ready = 1'($urandom_range(0, 1));
      endcase
      AXIS_TREADY = ready;
      if (beats == wrAtBeat) begin
        C_wr_en   = 1'b1;
        C_wr_addr = AB'(2);
        C_wr_data = OUTW'(99);
      end
      if (beats == cfAtBeat) compute_finished = 1'b1;
      tick();
      C_wr_en          = 1'b0;
      compute_finished = 1'b0;
      cycles++;
      if (ready) beats++;
      if (rstAtBeat >= 0 && beats == rstAtBeat) begin
        AXIS_TREADY = 1'b0;
        reset       = 1'b0;
        tick();
        reset = 1'b1;
        checkOutput("rstValid", 64'(AXIS_TVALID), 64'd0);
        checkOutput("rstReady", 64'(output_ready), 64'd1);
        checkOutput("rstLast", 64'(AXIS_TLAST), 64'd0);
        return;
      end
    end
    AXIS_TREADY = 1'b0;
    checkOutput("beatCount", 64'(beats), 64'(ELEMS));
    if (readyMode == 0) checkOutput("fullRate", 64'(cycles), 64'(ELEMS));
    checkOutput("endValid", 64'(AXIS_TVALID), 64'd0);
    checkOutput("endReady", 64'(output_ready), 64'd1);
    checkOutput("endLast", 64'(AXIS_TLAST), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset            = 1'b0;
    C_wr_en          = 1'b0;
    C_wr_addr        = '0;
    C_wr_data        = '0;
    compute_finished = 1'b0;
    AXIS_TREADY      = 1'b0;
    tick();
    tick();
    checkOutput("resetValid", 64'(AXIS_TVALID), 64'd0);
    checkOutput("resetLast", 64'(AXIS_TLAST), 64'd0);
    checkOutput("resetReady", 64'(output_ready), 64'd1);
    reset = 1'b1;
    tick();

    $display("[TB] basic stream");
    for (int i = 0; i < ELEMS; i++) writeElem(i, OUTW'(i + 1));
    applyStimulus(0, -1, -1, -1);

    $display("[TB] back-pressure");
    applyStimulus(1, -1, -1, -1);

    $display("[TB] signed extremes");
    writeElem(0, 28'hFFFFFFF);
    writeElem(1, 28'h8000000);
    writeElem(2, 28'h7FFFFFF);
    writeElem(3, 28'h0000000);
    writeElem(4, OUTW'(-5));
    writeElem(5, OUTW'(7));
    applyStimulus(1, -1, -1, -1);

    $display("[TB] writes during streaming");
    for (int i = 0; i < ELEMS; i++) writeElem(i, OUTW'(i + 1));
    applyStimulus(0, 1, -1, -1);
    applyStimulus(2, 0, -1, -1);

    $display("[TB] reset mid-stream");
    applyStimulus(0, -1, -1, 3);
    tick();
    applyStimulus(0, -1, -1, -1);

    $display("[TB] ignored compute_finished");
    applyStimulus(0, -1, 2, -1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("noRestart", 64'(AXIS_TVALID), 64'd0);
    end

    $display("[TB] write coincident with compute_finished");
    C_wr_en   = 1'b1;
    C_wr_addr = AB'(0);
    C_wr_data = 28'h5A5A5A5;
    refMem[0] = 28'h5A5A5A5;
    applyStimulus(0, -1, -1, -1);

    $display("[TB] random rounds");
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < (1 << AB); a++) writeElem(a, OUTW'($urandom));
      applyStimulus(2, -1, -1, -1);
      tick();
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
